// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART frame sequencer
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_DONE = 2'd2,
      GAP       = 2'd3
   } frm_state_t;

   localparam int DEF_BYTE_W = 8;

   // A zero or oversized request falls back to a full frame
   function automatic int eff_len(input int frm_len, input int num_bytes);
      if (frm_len == 0 || frm_len > num_bytes) return num_bytes;
      return frm_len;
   endfunction

endpackage

// File: rtl/frame_byte_mux.sv
// rtl/frame_byte_mux.sv - registered byte select from the captured frame payload
module frame_byte_mux
   import uart_pkg::*;
#(
   parameter int NUM_BYTES = 2,
   parameter int BYTE_W    = DEF_BYTE_W,
   parameter int IDX_W     = 1
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [NUM_BYTES*BYTE_W-1:0] i_payload,
   input  logic [IDX_W-1:0]            i_idx,
   output logic [BYTE_W-1:0]           o_tx_data
);

   logic [BYTE_W-1:0] r_tx_data;

   // Fed with next-cycle payload/index so the byte lines up with its index
   always_ff @(posedge i_clk) begin
      if (i_rst) r_tx_data <= '0;
      else       r_tx_data <= i_payload[i_idx*BYTE_W +: BYTE_W];
   end

   assign o_tx_data = r_tx_data;

endmodule

// File: rtl/frame_tx_ctrl.sv
// rtl/frame_tx_ctrl.sv - multi-byte frame sequencer driving the UART trmt/tx_done handshake
module frame_tx_ctrl
   import uart_pkg::*;
#(
   parameter int  NUM_BYTES  = 2,
   parameter int  BYTE_W     = DEF_BYTE_W,
   parameter int  GAP_CYCLES = 0,
   parameter int  LEN_W      = $clog2(NUM_BYTES + 1),
   localparam int IDX_W      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        snd_frm,
   input  logic [LEN_W-1:0]            frm_len,
   input  logic [NUM_BYTES*BYTE_W-1:0] frm_data,
   input  logic                        msb_first,
   input  logic                        tx_done,
   output logic                        trmt,
   output logic [BYTE_W-1:0]           tx_data,
   output logic [IDX_W-1:0]            byte_idx,
   output logic                        busy,
   output logic                        frm_cmplt
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   frm_state_t                  r_state, w_state_nxt;
   logic [NUM_BYTES*BYTE_W-1:0] r_payload, w_payload_nxt;
   logic [LEN_W-1:0]            r_len, w_len_eff;
   logic                        r_msb;
   logic [IDX_W-1:0]            r_idx, w_idx_nxt;
   logic [GAP_W-1:0]            r_gap_cnt;
   logic                        r_cmplt;
   logic                        w_accept, w_last, w_step, w_gap_end, w_final;

   assign w_len_eff = LEN_W'(eff_len(int'(frm_len), NUM_BYTES));
   assign w_accept  = (r_state == IDLE) && snd_frm;
   assign w_last    = r_msb ? (r_idx == '0) : (r_idx == IDX_W'(r_len - LEN_W'(1)));
   assign w_step    = (r_state == WAIT_DONE) && tx_done && !w_last;
   assign w_final   = (r_state == WAIT_DONE) && tx_done && w_last;
   assign w_gap_end = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:      if (snd_frm) w_state_nxt = SEND;
         SEND:      w_state_nxt = WAIT_DONE;
         WAIT_DONE: if (tx_done) w_state_nxt = w_last ? IDLE : ((GAP_CYCLES > 0) ? GAP : SEND);
         GAP:       if (w_gap_end) w_state_nxt = SEND;
         default:   w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      trmt = (r_state == SEND);
      busy = (r_state != IDLE);
   end

   always_comb begin
      w_payload_nxt = r_payload;
      w_idx_nxt     = r_idx;
      if (w_accept) begin
         w_payload_nxt = frm_data;
         w_idx_nxt     = msb_first ? IDX_W'(w_len_eff - LEN_W'(1)) : '0;
      end else if (w_step) begin
         w_idx_nxt = r_msb ? (r_idx - IDX_W'(1)) : (r_idx + IDX_W'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_payload <= '0;
         r_idx     <= '0;
         r_len     <= '0;
         r_msb     <= 1'b0;
         r_cmplt   <= 1'b0;
         r_gap_cnt <= '0;
      end else begin
         r_payload <= w_payload_nxt;
         r_idx     <= w_idx_nxt;
         if (w_accept) begin
            r_len <= w_len_eff;
            r_msb <= msb_first;
         end
         if (w_accept)     r_cmplt <= 1'b0;
         else if (w_final) r_cmplt <= 1'b1;
         if (r_state == GAP && !w_gap_end) r_gap_cnt <= r_gap_cnt + GAP_W'(1);
         else                              r_gap_cnt <= '0;
      end
   end

   frame_byte_mux #(
      .NUM_BYTES (NUM_BYTES),
      .BYTE_W    (BYTE_W),
      .IDX_W     (IDX_W)
   ) u_byte_mux (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_payload (w_payload_nxt),
      .i_idx     (w_idx_nxt),
      .o_tx_data (tx_data)
   );

   assign byte_idx  = r_idx;
   assign frm_cmplt = r_cmplt;

endmodule
